param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word, at least 1.
REQ-002 Parameter DEPTH, default 16: number of entries, a power of two and at least 2.
REQ-003 Parameter FWFT, default 0: read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_THRESH, default DEPTH-2: almost_full threshold, in the range 1..DEPTH.
REQ-005 Parameter AE_THRESH, default 2: almost_empty threshold, in the range 0..DEPTH-1.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 flush  in  1  synchronous clear of contents.
REQ-009 wr_valid  in  1  write request.
REQ-010 wr_ready  out  1  FIFO can accept a write.
REQ-011 wr_data  in  DATA_WIDTH  write word.
REQ-012 rd_ready  in  1  mode 0: read request; mode 1: consumer accepts the head word.
REQ-013 rd_valid  out  1  rd_data holds a valid word.
REQ-014 rd_data  out  DATA_WIDTH  read word.
REQ-015 count  out  clog2(DEPTH)+1  number of stored entries.
REQ-016 almost_full, almost_empty  out  1 each  threshold flags.
REQ-017 overflow, underflow  out  1 each  sticky error flags.
REQ-018 err_clr  in  1  clears the sticky error flags.

Function
REQ-019 wr_ready = (count != DEPTH); a write is accepted iff wr_valid && wr_ready, storing wr_data at wr_ptr, which then increments modulo DEPTH.
REQ-020 A read is accepted iff rd_ready && (count != 0); rd_ptr then increments modulo DEPTH.
REQ-021 Mode 0: on an accepted read, rd_data is registered from mem[rd_ptr] and rd_valid is 1 for exactly the next cycle; otherwise rd_valid = 0 and rd_data holds its value.
REQ-022 Mode 1: rd_valid = (count != 0) and rd_data = mem[rd_ptr] combinationally, with zero latency; rd_data is don't-care while rd_valid = 0.
REQ-023 count: +1 on a write alone, -1 on a read alone, unchanged when both or neither are accepted.
REQ-024 When full, a write is refused even if a read is accepted in the same cycle.
REQ-025 When empty, a read is refused even if a write is accepted in the same cycle; there is no bypass.
REQ-026 almost_full = (count >= AF_THRESH) and almost_empty = (count <= AE_THRESH), both decoded combinationally from the count register.
REQ-027 overflow is set on the cycle after wr_valid && !wr_ready.
REQ-028 underflow is set on the cycle after rd_ready && count == 0, in mode 0 only; in mode 1 underflow stays 0.
REQ-029 overflow and underflow remain 1 until err_clr; if err_clr and a new error occur in the same cycle, set wins.
REQ-030 flush zeroes wr_ptr, rd_ptr and count and forces rd_valid to 0 next cycle.
REQ-031 flush overrides any write or read in the same cycle; memory contents, the error flags and rd_data are unchanged by flush.

Reset
REQ-032 rst has priority over flush and all other inputs.
REQ-033 On rst: wr_ptr = 0, rd_ptr = 0, count = 0, rd_valid = 0, rd_data = 0 (mode 0), overflow = 0, underflow = 0.
REQ-034 Immediately after rst: wr_ready = 1, almost_empty = 1, almost_full = 0.
REQ-035 Memory is not reset.
REQ-036 rst asserted mid-burst discards all entries; any accepted write in that cycle is lost.

Structure
REQ-037 The shared package holds the read-mode constants (MODE_STD = 0, MODE_FWFT = 1) and the address-width helper function.
REQ-038 Storage is a sub-module param_fifo_mem: one synchronous write port, one asynchronous read port, parameterised by DATA_WIDTH and DEPTH.
REQ-039 Pointers, count, flags and the mode-0 output register live in param_fifo.

Verification
REQ-040 DEPTH=16, mode 0: write 0x01..0x10 -> wr_ready=0 after the 16th write and count=16; 16 reads return 0x01..0x10, each rd_valid one cycle after its rd_ready.
REQ-041 Full FIFO, wr_valid held 1 cycle with data 0xAA -> overflow=1 the next cycle, count stays 16, 0xAA is never read; err_clr -> overflow=0.
REQ-042 Mode 1: write 0x5A into empty -> rd_valid=1 and rd_data=0x5A the next cycle; rd_ready=1 -> rd_valid=0 and count=0 the following cycle.
REQ-043 count=8, simultaneous write and read for 20 cycles -> count stays 8, pointers wrap, read data is in exact FIFO order.
REQ-044 Thresholds AF=14, AE=2: fill from 0 -> almost_empty drops at count=3, almost_full rises at count=14.
REQ-045 count=5, then flush and wr_valid in the same cycle -> count=0 and rd_valid=0; separately, rst mid-burst -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared definitions for the parameterised FIFO: read-mode constants and sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package param_fifo_pkg;

    localparam int MODE_STD  = 0;  // registered read
    localparam int MODE_FWFT = 1;  // first-word-fall-through

    // Address width needed to index 'depth' entries. Clamped to 1 bit so a
    // degenerate depth still yields a legal vector width.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module param_fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, threshold flags and sticky errors.
// Latency: mode 0 read data one cycle after rd_ready; mode 1 head word visible the cycle after its write.
// Backpressure: wr_ready drops when full; reads on empty are refused (no bypass), flagged in mode 0.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clr
);

    localparam int AW = addr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    assign full   = (count_q == FULL_C);
    assign empty  = (count_q == '0);
    // Full refuses writes even alongside a read; empty refuses reads even
    // alongside a write, so there is never a same-cycle bypass path.
    assign wr_acc = wr_valid && !full;
    assign rd_acc = rd_ready && !empty;

    param_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !flush && !rst),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Pointers, occupancy and the mode-0 output register; flush clears
    // occupancy but leaves rd_data and memory untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + AW'(1);
                rd_data_q <= mem_rdata;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - CW'(1);
            end
            rd_valid_q <= rd_acc;
        end
    end

    // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if ((FWFT == MODE_STD) && rd_ready && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    assign wr_ready     = !full;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign rd_valid     = (FWFT == MODE_FWFT) ? !empty    : rd_valid_q;
    assign rd_data      = (FWFT == MODE_FWFT) ? mem_rdata : rd_data_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: one registered-read and one FWFT instance share stimulus.
// Latency: inputs driven #1 after the rising edge, outputs checked #1 after the next edge.
// Backpressure: exercised through full/empty refusal and sticky error flags.
module tb_param_fifo;
    import param_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic       err_clr;

    logic       wr_ready0, rd_valid0, af0, ae0, ovf0, unf0;
    logic [7:0] rd_data0;
    logic [4:0] count0;
    logic       wr_ready1, rd_valid1, af1, ae1, ovf1, unf1;
    logic [7:0] rd_data1;
    logic [4:0] count1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(MODE_STD), .AF_THRESH(14), .AE_THRESH(2)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid0), .rd_data(rd_data0),
        .count(count0), .almost_full(af0), .almost_empty(ae0),
        .overflow(ovf0), .underflow(unf0), .err_clr(err_clr)
    );

    param_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(MODE_FWFT), .AF_THRESH(14), .AE_THRESH(2)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .count(count1), .almost_full(af1), .almost_empty(ae1),
        .overflow(ovf1), .underflow(unf1), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs, then return to idle inputs.
    task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr,
                       input logic fl, input logic ec);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        err_clr  = ec;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},  32'(count0),    0);
        chk({tag, "_wrrdy"},  32'(wr_ready0), 1);
        chk({tag, "_ae"},     32'(ae0),       1);
        chk({tag, "_af"},     32'(af0),       0);
        chk({tag, "_rdvld"},  32'(rd_valid0), 0);
        chk({tag, "_rddat"},  32'(rd_data0),  0);
        chk({tag, "_ovf"},    32'(ovf0),      0);
        chk({tag, "_unf"},    32'(unf0),      0);
        chk({tag, "_rdvld1"}, 32'(rd_valid1), 0);
        chk({tag, "_count1"}, 32'(count1),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        rd_ready = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst");

        // Fill 0x01..0x10; almost_empty clears at 3, almost_full sets at 14.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_count", 32'(count0), i);
            chk("fill_ae",    32'(ae0),    32'(i <= 2));
            chk("fill_af",    32'(af0),    32'(i >= 14));
        end
        chk("full_wrrdy",  32'(wr_ready0), 0);
        chk("full_count1", 32'(count1),    16);

        // Write into full FIFO -> overflow, count unchanged.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("ovf_set",   32'(ovf0),   1);
        chk("ovf_count", 32'(count0), 16);
        chk("ovf_set1",  32'(ovf1),   1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr",   32'(ovf0),   0);

        // Full with simultaneous read: write refused, read proceeds.
        cyc(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        chk("fullrw_count", 32'(count0),   15);
        chk("fullrw_vld",   32'(rd_valid0), 1);
        chk("fullrw_dat",   32'(rd_data0), 32'h01);
        chk("fullrw_ovf",   32'(ovf0),     1);
        chk("fullrw_cnt1",  32'(count1),   15);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Drain the rest; 0xAA / 0xBB must never appear.
        for (int i = 2; i <= 16; i++) begin
            chk("drain_head1", 32'(rd_data1), i);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("drain_vld", 32'(rd_valid0), 1);
            chk("drain_dat", 32'(rd_data0),  i);
        end
        chk("drain_count", 32'(count0), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("idle_vld",  32'(rd_valid0), 0);
        chk("idle_hold", 32'(rd_data0),  32'h10);
        chk("idle_ovf",  32'(ovf0),      0);

        // Empty with simultaneous write: read refused, underflow in mode 0 only.
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("emptyrw_count", 32'(count0),    1);
        chk("emptyrw_vld",   32'(rd_valid0), 0);
        chk("emptyrw_unf",   32'(unf0),      1);
        chk("emptyrw_unf1",  32'(unf1),      0);
        chk("emptyrw_vld1",  32'(rd_valid1), 1);
        chk("emptyrw_dat1",  32'(rd_data1),  32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("rd77_dat", 32'(rd_data0), 32'h77);
        // Error and clear in the same cycle: set wins.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("unf_setwins", 32'(unf0), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("unf_clr", 32'(unf0), 0);

        // FWFT: zero-latency head word.
        do_reset();
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("fwft_vld",   32'(rd_valid1), 1);
        chk("fwft_dat",   32'(rd_data1),  32'h5A);
        chk("fwft_std0",  32'(rd_valid0), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_pop_vld", 32'(rd_valid1), 0);
        chk("fwft_pop_cnt", 32'(count1),    0);
        chk("std_pop_vld",  32'(rd_valid0), 1);
        chk("std_pop_dat",  32'(rd_data0),  32'h5A);

        // Streaming at count=8 with wrapping pointers.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(32'h20 + i), 1'b0, 1'b0, 1'b0);
        chk("stream_pre", 32'(count0), 8);
        for (int i = 0; i < 20; i++) begin
            chk("stream_head1", 32'(rd_data1), 32'h20 + i);
            cyc(1'b1, 8'(32'h28 + i), 1'b1, 1'b0, 1'b0);
            chk("stream_dat",   32'(rd_data0), 32'h20 + i);
            chk("stream_count", 32'(count0),   8);
        end
        chk("stream_count1", 32'(count1), 8);

        // Flush at count=5 with concurrent write and read.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(32'h40 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("preflush_count", 32'(count0),   5);
        chk("preflush_dat",   32'(rd_data0), 32'h40);
        cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        chk("flush_count",  32'(count0),    0);
        chk("flush_vld",    32'(rd_valid0), 0);
        chk("flush_dat",    32'(rd_data0),  32'h40);
        chk("flush_count1", 32'(count1),    0);
        chk("flush_vld1",   32'(rd_valid1), 0);

        // Reset mid-burst with error flag set and every input active.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_unf", 32'(unf0), 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(32'h60 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk_reset_state("midrst");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst_lost", 32'(count0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
